// File: rtl/sha_pkg.sv
// Constant sets shared by SHA-256/SHA-512 datapaths and the schedule FSM state type.
package sha_pkg;

    localparam int SHA256_WORD_W = 32;
    localparam int SHA256_ROUNDS = 64;
    localparam int SHA256_S0_R0  = 7;
    localparam int SHA256_S0_R1  = 18;
    localparam int SHA256_S0_SH  = 3;
    localparam int SHA256_S1_R0  = 17;
    localparam int SHA256_S1_R1  = 19;
    localparam int SHA256_S1_SH  = 10;

    localparam int SHA512_WORD_W = 64;
    localparam int SHA512_ROUNDS = 80;
    localparam int SHA512_S0_R0  = 1;
    localparam int SHA512_S0_R1  = 8;
    localparam int SHA512_S0_SH  = 7;
    localparam int SHA512_S1_R0  = 19;
    localparam int SHA512_S1_R1  = 61;
    localparam int SHA512_S1_SH  = 6;

    typedef enum logic {
        LOAD,
        EXPAND
    } sched_state_e;

endpackage

// File: rtl/lsigma.sv
// Lowercase sigma: ROR(R0) ^ ROR(R1) ^ SHR(SH), purely combinational.
module lsigma #(
    parameter int WORD_W = 32,
    parameter int R0     = 7,
    parameter int R1     = 18,
    parameter int SH     = 3
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int r);
        return (v >> r) | (v << (WORD_W - r));
    endfunction

    assign y = ror(x, R0) ^ ror(x, R1) ^ (x >> SH);

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message schedule expander: takes M[0..15] word-by-word, then streams
// W[16..ROUNDS-1] from a 16-word sliding window, one word per unstalled cycle.
//
// state  | meaning
// LOAD   | t < 16, message words pass straight through into window and output
// EXPAND | t >= 16, W[t] computed from the window, input side held off
module msg_schedule
    import sha_pkg::*;
#(
    parameter int WORD_W = SHA256_WORD_W,
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int S0_R0  = SHA256_S0_R0,
    parameter int S0_R1  = SHA256_S0_R1,
    parameter int S0_SH  = SHA256_S0_SH,
    parameter int S1_R0  = SHA256_S1_R0,
    parameter int S1_R1  = SHA256_S1_R1,
    parameter int S1_SH  = SHA256_S1_SH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_word,
    output logic [$clog2(ROUNDS)-1:0] out_idx,
    output logic                      out_last
);

    localparam int TW = $clog2(ROUNDS);
    localparam logic [TW-1:0] T_LOAD_END = TW'(15);
    localparam logic [TW-1:0] T_LAST     = TW'(ROUNDS - 1);

    sched_state_e      state;
    sched_state_e      state_next;
    logic [TW-1:0]     t;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] expand_word;
    logic [WORD_W-1:0] new_word;
    logic              out_free;
    logic              produce;

    lsigma #(.WORD_W(WORD_W), .R0(S0_R0), .R1(S0_R1), .SH(S0_SH)) u_sigma0 (
        .x (win[1]),
        .y (s0)
    );

    lsigma #(.WORD_W(WORD_W), .R0(S1_R0), .R1(S1_R1), .SH(S1_SH)) u_sigma1 (
        .x (win[14]),
        .y (s1)
    );

    assign out_free    = !out_valid || out_ready;
    assign in_ready    = (state == LOAD) && out_free;
    // Single-stage 4-operand add; carries past WORD_W fall off by width.
    assign expand_word = s1 + win[9] + s0 + win[0];

    always_comb begin
        state_next = state;
        produce    = 1'b0;
        new_word   = expand_word;
        unique case (state)
            LOAD: begin
                produce  = in_valid && out_free;
                new_word = in_word;
                if (produce && t == T_LOAD_END) state_next = EXPAND;
            end
            EXPAND: begin
                produce = out_free;
                if (produce && t == T_LAST) state_next = LOAD;
            end
        endcase
        if (clear) begin
            state_next = LOAD;
            produce    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t         <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (clear) begin
            t         <= '0;
            out_valid <= 1'b0;
        end else if (produce) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15]   <= new_word;
            out_word  <= new_word;
            out_idx   <= t;
            out_last  <= (t == T_LAST);
            out_valid <= 1'b1;
            t         <= (t == T_LAST) ? '0 : t + TW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: SHA-256 and SHA-512 instances share stimulus,
// a reference schedule model plus hand-computed words check the streamed output.
module tb_msg_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_word;
    logic        sel;

    logic        ir_a, ov_a, ol_a;
    logic [31:0] ow_a;
    logic [5:0]  oi_a;
    logic        ir_b, ov_b, ol_b;
    logic [63:0] ow_b;
    logic [6:0]  oi_b;

    logic        ir, ov, ol;
    logic [63:0] ow;
    logic [6:0]  oi;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] blk   [16];
    logic [63:0] exp_w [80];
    logic [63:0] got_w [80];

    typedef struct {
        logic [31:0] m0;
        logic [31:0] m15;
        int          idx;
        logic [31:0] w;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    msg_schedule u_dut256 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (ir_a),
        .in_word   (in_word[31:0]),
        .out_valid (ov_a),
        .out_ready (out_ready),
        .out_word  (ow_a),
        .out_idx   (oi_a),
        .out_last  (ol_a)
    );

    msg_schedule #(
        .WORD_W(64), .ROUNDS(80),
        .S0_R0(1), .S0_R1(8), .S0_SH(7),
        .S1_R0(19), .S1_R1(61), .S1_SH(6)
    ) u_dut512 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (ir_b),
        .in_word   (in_word),
        .out_valid (ov_b),
        .out_ready (out_ready),
        .out_word  (ow_b),
        .out_idx   (oi_b),
        .out_last  (ol_b)
    );

    always_comb begin
        if (sel) begin
            ir = ir_b; ov = ov_b; ol = ol_b; ow = ow_b; oi = oi_b;
        end else begin
            ir = ir_a; ov = ov_a; ol = ol_a; ow = {32'b0, ow_a}; oi = {1'b0, oi_a};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
        logic [63:0] m;
        m = (n == 64) ? '1 : ((64'h1 << n) - 64'h1);
        x = x & m;
        return ((x >> r) | (x << (n - r))) & m;
    endfunction

    task automatic build_model(input int n, input int rounds,
                               input int a0, input int a1, input int as,
                               input int b0, input int b1, input int bs);
        logic [63:0] m, x0, x1, s0, s1;
        m = (n == 64) ? '1 : ((64'h1 << n) - 64'h1);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i] & m;
        for (int i = 16; i < rounds; i++) begin
            x0 = exp_w[i-15];
            x1 = exp_w[i-2];
            s0 = ror(x0, a0, n) ^ ror(x0, a1, n) ^ (x0 >> as);
            s1 = ror(x1, b0, n) ^ ror(x1, b1, n) ^ (x1 >> bs);
            exp_w[i] = (s1 + exp_w[i-7] + s0 + exp_w[i-16]) & m;
        end
    endtask

    task automatic clear_pulse();
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_idle_ov", {63'b0, ov}, 64'd0);
    endtask

    // abort_kind: 0 = run to end, 1 = clear at abort_idx, 2 = async rst at abort_idx
    task automatic run_block(input int rounds, input int stall_pct,
                             input int abort_kind, input int abort_idx);
        int          got, mi, cyc;
        logic        pstall;
        logic [63:0] pw;
        logic [6:0]  pi;
        got = 0; mi = 0; cyc = 0; pstall = 1'b0; pw = '0; pi = '0;
        while (got < rounds && cyc < 2000) begin
            out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            in_valid  = (mi < 16);
            in_word   = (mi < 16) ? blk[mi] : '0;
            #1;
            if (pstall) begin
                check("stall_valid", {63'b0, ov}, 64'd1);
                check("stall_word", ow, pw);
                check("stall_idx", {57'b0, oi}, {57'b0, pi});
            end
            if (abort_kind == 1 && ov && int'(oi) == abort_idx) begin
                clear = 1'b1; in_valid = 1'b0;
                @(posedge clk); #1;
                clear = 1'b0; out_ready = 1'b1;
                check("clear_ov", {63'b0, ov}, 64'd0);
                repeat (5) begin
                    @(posedge clk); #1;
                    check("clear_quiet", {63'b0, ov}, 64'd0);
                end
                return;
            end
            if (abort_kind == 2 && ov && int'(oi) == abort_idx) begin
                #1 rst = 1'b1;
                #1;
                check("rst_ov", {63'b0, ov}, 64'd0);
                check("rst_ir", {63'b0, ir}, 64'd1);
                in_valid = 1'b1; in_word = blk[0];
                repeat (2) @(posedge clk);
                #3 in_valid = 1'b0; rst = 1'b0;
                @(posedge clk); #1;
                check("rst_release_ov", {63'b0, ov}, 64'd0);
                check("rst_release_idx", {57'b0, oi}, 64'd0);
                check("rst_release_word", ow, 64'd0);
                return;
            end
            if (stall_pct == 0)
                check("in_ready", {63'b0, ir}, (cyc < 16 || cyc >= rounds) ? 64'd1 : 64'd0);
            if (ov && out_ready) begin
                check("idx", {57'b0, oi}, 64'(got));
                check("word", ow, exp_w[got]);
                check("last", {63'b0, ol}, (got == rounds - 1) ? 64'd1 : 64'd0);
                got_w[got] = ow;
                got++;
            end
            if (in_valid && ir) mi++;
            pstall = ov && !out_ready;
            pw = ow; pi = oi;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("words_seen", 64'(got), 64'(rounds));
        if (stall_pct == 0) check("block_cycles", 64'(cyc), 64'(rounds + 1));
    endtask

    task automatic load_abc256();
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 64'h61626380;
        blk[15] = 64'h18;
        build_model(32, 64, 7, 18, 3, 17, 19, 10);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_word = '0; sel = 1'b0;

        vecs[0] = '{32'h61626380, 32'h18, 16, 32'h61626380};
        vecs[1] = '{32'h61626380, 32'h18, 17, 32'h000F0000};
        vecs[2] = '{32'h61626380, 32'h18, 63, 32'h12B1EDEB};
        vecs[3] = '{32'h61626380, 32'h18, 0,  32'h61626380};
        vecs[4] = '{32'h61626380, 32'h18, 15, 32'h00000018};
        vecs[5] = '{32'h0,        32'h0,  16, 32'h0};
        vecs[6] = '{32'h0,        32'h0,  63, 32'h0};
        vecs[7] = '{32'h1,        32'h0,  16, 32'h1};
        vecs[8] = '{32'h0,        32'h18, 17, 32'h000F0000};

        #2;
        check("reset_ir", {63'b0, ir_a}, 64'd1);
        check("reset_ov", {63'b0, ov_a}, 64'd0);
        check("reset_word", {32'b0, ow_a}, 64'd0);
        check("reset_idx", {58'b0, oi_a}, 64'd0);
        check("reset_last", {63'b0, ol_a}, 64'd0);
        check("reset_ov512", {63'b0, ov_b}, 64'd0);
        in_valid = 1'b1; in_word = 64'hDEADBEEF;
        @(posedge clk); #1;
        check("reset_ignores_in", {63'b0, ov_a}, 64'd0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < 16; i++) blk[i] = '0;
            blk[0]  = {32'b0, vecs[v].m0};
            blk[15] = {32'b0, vecs[v].m15};
            build_model(32, 64, 7, 18, 3, 17, 19, 10);
            clear_pulse();
            run_block(64, 0, 0, 0);
            check("vec_w", got_w[vecs[v].idx], {32'b0, vecs[v].w});
        end

        load_abc256();
        clear_pulse();
        run_block(64, 30, 0, 0);
        check("stall_w63", got_w[63], 64'h12B1EDEB);

        run_block(64, 0, 1, 20);
        run_block(64, 0, 0, 0);
        check("after_clear_w63", got_w[63], 64'h12B1EDEB);

        run_block(64, 0, 2, 30);
        run_block(64, 0, 0, 0);
        check("after_rst_w17", got_w[17], 64'h000F0000);

        sel = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 64'h6162638000000000;
        blk[15] = 64'h18;
        build_model(64, 80, 1, 8, 7, 19, 61, 6);
        clear_pulse();
        run_block(80, 0, 0, 0);
        check("w512_16", got_w[16], 64'h6162638000000000);
        check("w512_17", got_w[17], 64'h00030000000000C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/msg_schedule.md
# msg_schedule

Parametrised message-schedule expander for the SHA-2 core. Accepts one 16-word message block word-by-word and streams the full schedule W[0..ROUNDS-1] to the compression round logic, one word per cycle when unstalled. Word width, round count and lowercase-sigma rotate/shift amounts are parameters, so one block serves both SHA-256 (default) and SHA-512.

## Interface

Parameters:
- WORD_W, 32, schedule word width in bits (64 for SHA-512)
- ROUNDS, 64, schedule words per block (80 for SHA-512); must be > 16
- S0_R0, 7; S0_R1, 18; S0_SH, 3: sigma0 = ROR(S0_R0) ^ ROR(S0_R1) ^ SHR(S0_SH)
- S1_R0, 17; S1_R1, 19; S1_SH, 10: sigma1 = ROR(S1_R0) ^ ROR(S1_R1) ^ SHR(S1_SH)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort of the current block
- in_valid  in  1  in_word valid
- in_ready  out  1  block accepts in_word
- in_word  in  WORD_W  message word M[t], t = 0..15, big-endian word order
- out_valid  out  1  out_word valid
- out_ready  in  1  consumer accepts out_word
- out_word  out  WORD_W  schedule word W[out_idx]
- out_idx  out  $clog2(ROUNDS)  index t of out_word
- out_last  out  1  high with W[ROUNDS-1]

## Operation

- Window: 16 x WORD_W shift register; w[0] = W[t-16] (oldest), w[15] = W[t-1]. Each produced word shifts in at w[15]; w[0] drops.
- Counter t (0..ROUNDS-1) = index of the next word to produce.
- States:
  - LOAD (t < 16): in_ready = out_free, where out_free = !out_valid || out_ready. On in_valid && in_ready: W[t] = in_word is loaded into the output register and the window; t++. When t reaches 16, go to EXPAND.
  - EXPAND (t >= 16): in_ready = 0. When out_free: W[t] = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], mod 2^WORD_W (carries beyond WORD_W discarded). W[t] is loaded into the output register and the window; t++.
  - After the word with t = ROUNDS-1 is produced: t = 0, go to LOAD. That word drains normally, and in_ready may be high in the same cycle it is consumed.
- Output register: out_word, out_idx and out_last are captured together with out_valid set. Held stable while out_valid && !out_ready.
- clear: highest-priority synchronous event. Next cycle: state LOAD, t = 0, out_valid = 0, window contents don't-care. Concurrent in/out handshakes in that cycle are discarded.
- Reset values: state LOAD, t = 0, out_valid 0, out_word 0, out_idx 0, out_last 0, window all 0. in_ready is combinational and reads 1 during reset. in_valid is ignored while rst is high.
- rst asserted mid-block: the block is lost, with no partial output after release.

## Timing

- Latency: a word accepted at edge N is on out_word with out_valid at N (valid after edge N). A consumer with out_ready high takes it at edge N+1.
- Throughput: 1 word/cycle in both states. With in_valid and out_ready held high, one block completes in ROUNDS cycles. Back-to-back blocks have no bubble.
- Stall: while out_ready is low and out_valid is high, the window, t and state are frozen.
- Combinational paths: in_ready depends on out_ready. There is no path from in_valid to out_*.
- Critical path: a 4-operand WORD_W adder after the sigma XORs. No pipelining inside; the adder must close timing as a single stage.

## Structure

- Shared package sha_pkg:
  - SHA-256 constant set: 32/64, 7/18/3, 17/19/10.
  - SHA-512 constant set: 64/80, 1/8/7, 19/61/6.
  - State enum {LOAD, EXPAND}.
- Sub-module lsigma (parameters WORD_W, R0, R1, SH): combinational ROR ^ ROR ^ SHR. Instantiated twice, for sigma0 and sigma1.
- All other logic sits in msg_schedule: FSM, counter, window and output register.

## Test plan

- SHA-256 "abc" block. Stimulus: M[0] = 0x61626380, M[1..14] = 0, M[15] = 0x00000018, out_ready = 1. Required: W[16] = 0x61626380, W[17] = 0x000F0000, W[63] = 0x12B1EDEB, out_last only on idx 63, 64 words in 64 cycles.
- All-zero block. Required: all 64 W = 0. in_ready low for exactly cycles 16..63, then high again.
- Random out_ready stall (30 % low) on the "abc" block. Required: identical word sequence. out_word/out_idx stable while stalled, with no drops or duplicates.
- clear asserted at t = 20, then the "abc" block resent. Required: no further words from the aborted block, then the correct W[0..63].
- rst pulsed asynchronously mid-EXPAND. Required: out_valid = 0 immediately. After release the block restarts cleanly at idx 0.
- SHA-512 parameter set, FIPS 180-4 "abc" block. Required: W[16] matches the reference model, 80 words, out_last on idx 79, and carries truncated at 64 bits.
